dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the core's load/store port. It accepts word-addressed read and write requests from the core's LSU over a req/gnt/rvalid handshake and stores data in a byte-enabled word RAM. A programmable number of wait states can be inserted before each grant, so the core's stall path is exercised deterministically. It replaces the plain data RAM in the top level, and benches preload it through the hierarchical array `mem`.

## Interface

- `DEPTH_WORDS`, default 1024: number of 32-bit words in `mem`; must be a power of two.
- `WAIT_STATES`, default 0: cycles between request assertion and grant, range 0..15.
- `clk` input, 1 bit: single clock; all state changes on its rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `data_req_i` input, 1 bit: core requests an access; held with stable address and data until granted.
- `data_we_i` input, 1 bit: 1 = store, 0 = load.
- `data_be_i` input, 4 bits: byte-lane enables for stores; ignored for loads.
- `data_addr_i` input, 32 bits: byte address; bits [1:0] are ignored and bits above [1:0] form the word index.
- `data_wdata_i` input, 32 bits: store data, already lane-aligned by the core.
- `data_gnt_o` output, 1 bit: request accepted this cycle; combinational.
- `data_rvalid_o` output, 1 bit: response valid; registered, one-cycle pulse per accepted request.
- `data_rdata_o` output, 32 bits: load data, valid while `data_rvalid_o` is 1; 0 for stores and errors.
- `data_err_o` output, 1 bit: access out of range; valid while `data_rvalid_o` is 1.

## Operation

- Storage: `reg [31:0] mem [0:DEPTH_WORDS-1]`. It is not cleared by `rst`, so preloaded contents survive reset.
- FSM states:
  - IDLE:
    - `data_req_i`=1 and `WAIT_STATES`=0: grant in the same cycle and stay in IDLE.
    - `data_req_i`=1 and `WAIT_STATES`>0: no grant; load `wcnt`=`WAIT_STATES`-1 and go to STALL.
  - STALL:
    - `data_req_i`=0: abort with no access and no response; go to IDLE.
    - `wcnt`≠0: decrement `wcnt`.
    - `wcnt`=0 and `data_req_i`=1: grant and go to IDLE.
- `data_gnt_o` = `data_req_i` & ((IDLE & `WAIT_STATES`==0) | (STALL & `wcnt`==0)).
- Accepted access, on the rising edge where `data_gnt_o`=1:
  - Word index `idx` = `data_addr_i`[log2(DEPTH_WORDS)+1:2]. The access is out of range when any of `data_addr_i`[31:log2(DEPTH_WORDS)+2] is set.
  - In-range store: write each byte lane k whose `data_be_i`[k]=1 with `data_wdata_i`[8k+7:8k]. Leave the other lanes unchanged.
  - In-range load: register `mem[idx]` into `data_rdata_o`. The read returns the contents before any same-edge write, but a write and a read cannot occur on the same edge.
  - Out of range: no write; `data_rdata_o`=0 and `data_err_o`=1.
- Response: on the edge after the grant, `data_rvalid_o`=1 for exactly one cycle. When no response is due, `data_rvalid_o`, `data_err_o` and `data_rdata_o` all return to 0.
- Back-to-back traffic with `WAIT_STATES`=0: a request held high is granted every cycle. The response to request N coincides with the grant of request N+1.
- With `WAIT_STATES`=W>0, every request, including consecutive ones, waits W cycles. The FSM passes through IDLE after each grant.

## Timing

- Reset state: FSM in IDLE, `wcnt`=0, `data_rvalid_o`=0, `data_err_o`=0, `data_rdata_o`=0.
  - `data_gnt_o` is forced to 0 during any cycle with `rst`=1.
- Reset during STALL or with a response pending: the pending access is dropped and no response is issued. A store granted on the edge where `rst` is sampled high is not written.
- Grant latency from `data_req_i` rising: `WAIT_STATES` cycles. Response latency from grant: 1 cycle.
- Request dropped during STALL: aborted as described under Operation. This is a protocol violation by the core, but the responder must handle it cleanly.
- `data_rdata_o` must not change except on a response edge or on the return to 0.

## Test plan

- **Aligned load:** preload `mem[1]`=32'hDEADBEEF, W=0; load from address 0x4 → `gnt` in the same cycle, `rvalid`=1 one cycle later, `rdata`=32'hDEADBEEF, `err`=0.
- **Byte-enabled store:** `mem[2]`=32'h11223344; store `be`=4'b0110, `wdata`=32'hAABBCCDD to address 0x8 → the load that follows returns 32'h11BBCC44, and the store's own response has `rdata`=0.
- **Wait states:** W=3; a load held from cycle 0 → `gnt` only in cycle 3, `rvalid` in cycle 4; `gnt` stays low in cycles 0–2.
- **Back-to-back with W=0:**
  - Three loads to 0x0, 0x4 and 0x8 with `req` held → `gnt` asserted for 3 consecutive cycles and `rvalid` for 3 consecutive cycles, one cycle later.
  - The data arrives in order.
- **Out of range:** DEPTH_WORDS=1024; store to address 0x1000 → granted, `rvalid` with `err`=1 and `rdata`=0; `mem[0]` is unchanged.
- **Reset mid-stall:** W=4, `rst` asserted in cycle 2 of a store → no `gnt` and no `rvalid`; the target word is unchanged; preloaded `mem` contents still read back correctly after reset.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the core load/store port.
//
// Accepts word-addressed loads and stores over a req/gnt/rvalid handshake
// and keeps the data in a byte-enabled 32-bit word RAM (`mem`). A fixed
// number of wait states can be inserted before every grant.
//
// Ports:
//   clk            clock, all state changes on the rising edge
//   rst            synchronous active-high reset (does not clear `mem`)
//   data_req_i     request; held with stable address/data until granted
//   data_we_i      1 = store, 0 = load
//   data_be_i      byte-lane enables for stores
//   data_addr_i    byte address, [1:0] ignored
//   data_wdata_i   lane-aligned store data
//   data_gnt_o     request accepted this cycle (combinational)
//   data_rvalid_o  one-cycle response pulse, the cycle after the grant
//   data_rdata_o   load data while data_rvalid_o, else 0
//   data_err_o     out-of-range access flag while data_rvalid_o
//   state_dbg      current FSM state (0 = IDLE, 1 = STALL)
//
// Handshake: an access is accepted on the rising edge where data_req_i and
// data_gnt_o are both 1. Exactly one response (data_rvalid_o = 1 for one
// cycle) follows on the next rising edge. Grants are never issued while rst
// is high, and an access abandoned before its grant gets no response.

module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        state_dbg
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam bit NO_WAIT = (WAIT_STATES == 0);
  // Counter preload: STALL grants when the counter reaches 0, so W wait
  // states need W-1 decrements after the IDLE cycle.
  localparam logic [3:0] WCNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_t;

  logic [31:0] mem [0:DEPTH_WORDS-1];

  state_t        state_q, state_d;
  logic [3:0]    wcnt_q, wcnt_d;
  logic          gnt;
  logic [AW-1:0] idx;
  logic          in_range;
  logic          unused_addr_bits;

  assign idx              = data_addr_i[AW+1:2];
  assign in_range         = (data_addr_i[31:AW+2] == '0);
  assign unused_addr_bits = ^data_addr_i[1:0];
  assign data_gnt_o       = gnt;
  assign state_dbg        = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wcnt_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    gnt     = 1'b0;
    case (state_q)
      IDLE: begin
        if (data_req_i) begin
          if (NO_WAIT) begin
            gnt = 1'b1;
          end else begin
            wcnt_d  = WCNT_INIT;
            state_d = STALL;
          end
        end
      end
      STALL: begin
        if (!data_req_i) begin
          // Core withdrew the request: drop it without any access.
          state_d = IDLE;
          wcnt_d  = 4'd0;
        end else if (wcnt_q != 4'd0) begin
          wcnt_d = wcnt_q - 4'd1;
        end else begin
          gnt     = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        wcnt_d  = 4'd0;
      end
    endcase
    if (rst) gnt = 1'b0;
  end

  // RAM write port; gnt is already suppressed during reset.
  always_ff @(posedge clk) begin
    if (gnt && data_we_i && in_range) begin
      for (int k = 0; k < 4; k++) begin
        if (data_be_i[k]) mem[idx][8*k +: 8] <= data_wdata_i[8*k +: 8];
      end
    end
  end

  // Response registers: return to zero whenever no response is due.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_rvalid_o <= 1'b0;
      data_err_o    <= 1'b0;
      data_rdata_o  <= 32'h0;
    end else begin
      data_rvalid_o <= gnt;
      data_err_o    <= gnt && !in_range;
      data_rdata_o  <= (gnt && !data_we_i && in_range) ? mem[idx] : 32'h0;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one instance without wait states (index 0) and
// one with three wait states (index 1), checked against a word-array model.

module tb_dmem_responder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst    [2];
  logic        req    [2];
  logic        we     [2];
  logic [3:0]  be     [2];
  logic [31:0] addr   [2];
  logic [31:0] wdata  [2];
  logic        gnt    [2];
  logic        rvalid [2];
  logic [31:0] rdata  [2];
  logic        err    [2];
  logic        dbg    [2];

  int checks   = 0;
  int failures = 0;

  logic [31:0] ref_mem [2][1024];
  logic [32:0] exp_q0[$];
  logic [32:0] exp_q1[$];

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst[0]), .data_req_i(req[0]), .data_we_i(we[0]),
    .data_be_i(be[0]), .data_addr_i(addr[0]), .data_wdata_i(wdata[0]),
    .data_gnt_o(gnt[0]), .data_rvalid_o(rvalid[0]), .data_rdata_o(rdata[0]),
    .data_err_o(err[0]), .state_dbg(dbg[0])
  );

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(3)) dut1 (
    .clk(clk), .rst(rst[1]), .data_req_i(req[1]), .data_we_i(we[1]),
    .data_be_i(be[1]), .data_addr_i(addr[1]), .data_wdata_i(wdata[1]),
    .data_gnt_o(gnt[1]), .data_rvalid_o(rvalid[1]), .data_rdata_o(rdata[1]),
    .data_err_o(err[1]), .state_dbg(dbg[1])
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [32:0] got, input logic [32:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Transaction-level model: returns {err, rdata} of the response and
  // applies stores to the reference word array.
  function automatic logic [32:0] model_access(input int d, input logic w, input logic [3:0] b,
                                               input logic [31:0] a, input logic [31:0] wd);
    int idx;
    if (a[31:12] != 20'h0) return {1'b1, 32'h0};
    idx = int'(a[11:2]);
    if (!w) return {1'b0, ref_mem[d][idx]};
    for (int k = 0; k < 4; k++) begin
      if (b[k]) ref_mem[d][idx][8*k +: 8] = wd[8*k +: 8];
    end
    return 33'h0;
  endfunction

  // ---------------- scoreboards ----------------
  always @(negedge clk) begin
    check("rvalid0", {32'b0, rvalid[0]}, {32'b0, exp_q0.size() != 0});
    if (exp_q0.size() != 0) check("resp0", {err[0], rdata[0]}, exp_q0.pop_front());
    else                    check("quiet0", {err[0], rdata[0]}, 33'h0);
    if (rst[0] || !req[0])  check("gnt0_low", {32'b0, gnt[0]}, 33'h0);
    if (rst[0]) exp_q0.delete();
    else if (gnt[0]) exp_q0.push_back(model_access(0, we[0], be[0], addr[0], wdata[0]));
  end

  always @(negedge clk) begin
    check("rvalid1", {32'b0, rvalid[1]}, {32'b0, exp_q1.size() != 0});
    if (exp_q1.size() != 0) check("resp1", {err[1], rdata[1]}, exp_q1.pop_front());
    else                    check("quiet1", {err[1], rdata[1]}, 33'h0);
    if (rst[1] || !req[1])  check("gnt1_low", {32'b0, gnt[1]}, 33'h0);
    if (rst[1]) exp_q1.delete();
    else if (gnt[1]) exp_q1.push_back(model_access(1, we[1], be[1], addr[1], wdata[1]));
  end

  // ---------------- driver ----------------
  // Called just after a rising edge. Holds the request until granted, checks
  // the grant latency, and (unless keep) drops req and returns the response.
  task automatic access(input int d, input logic w, input logic [3:0] b, input logic [31:0] a,
                        input logic [31:0] wd, input bit keep, output logic [32:0] resp);
    int waited = 0;
    int lat_exp;
    lat_exp = (d == 0) ? 0 : 3;
    we[d] = w; be[d] = b; addr[d] = a; wdata[d] = wd; req[d] = 1'b1;
    @(negedge clk);
    while (!gnt[d] && waited < 40) begin
      waited++;
      @(negedge clk);
    end
    check("grant_latency", 33'(waited), 33'(lat_exp));
    @(posedge clk); #1;
    resp = 33'h0;
    if (!keep) begin
      req[d] = 1'b0;
      @(negedge clk);
      resp = {err[d], rdata[d]};
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = {20'h0, 10'($urandom_range(0, 1023)), 2'($urandom_range(0, 3))};
    if ($urandom_range(0, 7) == 0) a[$urandom_range(12, 31)] = 1'b1;
    return a;
  endfunction

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [32:0] r;
    logic [31:0] v;
    int n;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; req[d] = 1'b0; we[d] = 1'b0; be[d] = 4'h0;
      addr[d] = 32'h0; wdata[d] = 32'h0;
    end
    for (int i = 0; i < 1024; i++) begin
      v = $urandom; dut0.mem[i] = v; ref_mem[0][i] = v;
      v = $urandom; dut1.mem[i] = v; ref_mem[1][i] = v;
    end
    dut0.mem[0] = 32'hCAFEF00D; ref_mem[0][0] = 32'hCAFEF00D;
    dut0.mem[1] = 32'hDEADBEEF; ref_mem[0][1] = 32'hDEADBEEF;
    dut0.mem[2] = 32'h11223344; ref_mem[0][2] = 32'h11223344;
    dut1.mem[1] = 32'hDEADBEEF; ref_mem[1][1] = 32'hDEADBEEF;
    dut1.mem[8] = 32'h5A5A1234; ref_mem[1][8] = 32'h5A5A1234;

    repeat (3) @(posedge clk);
    #1;
    rst[0] = 1'b0; rst[1] = 1'b0;
    check("reset_state0", {32'b0, dbg[0]}, 33'h0);
    check("reset_state1", {32'b0, dbg[1]}, 33'h0);

    // Aligned load, W=0.
    access(0, 1'b0, 4'hF, 32'h4, 32'h0, 1'b0, r);
    check("aligned_load", r, {1'b0, 32'hDEADBEEF});

    // Byte-enabled store and read-back.
    access(0, 1'b1, 4'b0110, 32'h8, 32'hAABBCCDD, 1'b0, r);
    check("store_resp", r, 33'h0);
    access(0, 1'b0, 4'hF, 32'h8, 32'h0, 1'b0, r);
    check("be_merge", r, {1'b0, 32'h11BBCC44});

    // Wait states, W=3.
    access(1, 1'b0, 4'hF, 32'h4, 32'h0, 1'b0, r);
    check("wait_load", r, {1'b0, 32'hDEADBEEF});

    // Back-to-back loads with req held, W=0.
    access(0, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1, r);
    access(0, 1'b0, 4'hF, 32'h4, 32'h0, 1'b1, r);
    access(0, 1'b0, 4'hF, 32'h8, 32'h0, 1'b0, r);
    check("b2b_last", r, {1'b0, 32'h11BBCC44});

    // Out-of-range store leaves mem[0] alone.
    access(0, 1'b1, 4'hF, 32'h1000, 32'h12345678, 1'b0, r);
    check("oor_resp", r, {1'b1, 32'h0});
    access(0, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0, r);
    check("oor_mem0", r, {1'b0, 32'hCAFEF00D});

    // Reset in cycle 2 of a stalled store, W=3.
    we[1] = 1'b1; be[1] = 4'hF; addr[1] = 32'h20; wdata[1] = 32'h0BADC0DE; req[1] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) rst[1] = 1'b1;
      @(negedge clk);
      check("stall_no_gnt", {32'b0, gnt[1]}, 33'h0);
      @(posedge clk); #1;
    end
    rst[1] = 1'b0; req[1] = 1'b0;
    check("post_rst_state", {32'b0, dbg[1]}, 33'h0);
    repeat (3) @(posedge clk);
    #1;
    access(1, 1'b0, 4'hF, 32'h20, 32'h0, 1'b0, r);
    check("rst_word_kept", r, {1'b0, 32'h5A5A1234});
    access(1, 1'b0, 4'hF, 32'h4, 32'h0, 1'b0, r);
    check("preload_kept", r, {1'b0, 32'hDEADBEEF});

    // Randomized traffic, W=0 with random back-to-back runs.
    n = 200;
    for (int i = 0; i < n; i++) begin
      access(0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), rand_addr(), $urandom,
             (i < n - 1) ? 1'($urandom_range(0, 1)) : 1'b0, r);
    end

    // Randomized traffic, W=3, including held consecutive requests.
    n = 60;
    for (int i = 0; i < n; i++) begin
      access(1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), rand_addr(), $urandom,
             (i < n - 1) ? 1'($urandom_range(0, 1)) : 1'b0, r);
    end

    repeat (4) @(negedge clk);
    check("drain0", 33'(exp_q0.size()), 33'h0);
    check("drain1", 33'(exp_q1.size()), 33'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
